wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 16, meaning the address bus width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width.
REQ-003 The module SHALL have parameter GRANULE, default 8, meaning the select granularity; SEL_WIDTH = DATA_WIDTH/GRANULE.
REQ-004 The module SHALL have parameter MASTER_NUM, default 4, meaning the number of masters (legal range 2..8).
REQ-005 The module SHALL have a single clock, clk_i; reset rst_i SHALL be synchronous and active-high.
REQ-006 Port clk_i: input, 1 bit, clock; all state changes on its rising edge.
REQ-007 Port rst_i: input, 1 bit, synchronous active-high reset.
REQ-008 Port m_cyc_i: input, MASTER_NUM bits, per-master CYC (bus request).
REQ-009 Port m_stb_i: input, MASTER_NUM bits, per-master STB.
REQ-010 Port m_we_i: input, MASTER_NUM bits, per-master WE.
REQ-011 Port m_adr_i: input, MASTER_NUM*ADDR_WIDTH bits, master k at slice [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 Port m_dat_i: input, MASTER_NUM*DATA_WIDTH bits, per-master write data, same slicing.
REQ-013 Port m_sel_i: input, MASTER_NUM*SEL_WIDTH bits, per-master SEL, same slicing.
REQ-014 Port m_dat_o: output, DATA_WIDTH bits, read data broadcast to all masters.
REQ-015 Port m_ack_o: output, MASTER_NUM bits, per-master ACK.
REQ-016 Ports s_cyc_o, s_stb_o, s_we_o: outputs, 1 bit each, to the shared slave.
REQ-017 Ports s_adr_o (ADDR_WIDTH), s_dat_o (DATA_WIDTH), s_sel_o (SEL_WIDTH): outputs to the slave.
REQ-018 Ports s_dat_i (DATA_WIDTH) and s_ack_i (1): inputs from the slave.
REQ-019 Port gnt_o: output, MASTER_NUM bits, one-hot current grant; all-zero when no grant is held.

Function
REQ-020 The arbiter SHALL implement states ARB_IDLE and ARB_GRANTED.
REQ-021 In ARB_IDLE with any m_cyc_i bit set, the arbiter SHALL register a grant to the first requesting master searching upward, with wrap-around, from last_gnt+1, and SHALL enter ARB_GRANTED on the next edge.
REQ-022 Grant latency SHALL be exactly one clock from m_cyc_i assertion in ARB_IDLE to gnt_o and s_cyc_o assertion.
REQ-023 In ARB_GRANTED, the grant SHALL hold while m_cyc_i[gnt] is 1, regardless of other requests, so that multi-phase cycles (RMW) are never split.
REQ-024 When m_cyc_i[gnt] is 0 in ARB_GRANTED, the arbiter SHALL return to ARB_IDLE on the next edge and SHALL set last_gnt to gnt; the next grant SHALL appear no earlier than one cycle later (one idle cycle between tenures).
REQ-025 In ARB_GRANTED, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o and s_sel_o SHALL combinationally equal the granted master's signals, with s_cyc_o = m_cyc_i[gnt] and s_stb_o = m_stb_i[gnt] & m_cyc_i[gnt].
REQ-026 In ARB_IDLE, s_cyc_o and s_stb_o SHALL be 0 and the other slave outputs SHALL be 0.
REQ-027 m_ack_o[gnt] SHALL equal s_ack_i & m_cyc_i[gnt] in ARB_GRANTED; all other m_ack_o bits SHALL be 0 at all times.
REQ-028 m_dat_o SHALL equal s_dat_i combinationally at all times.
REQ-029 A stray s_ack_i in ARB_IDLE SHALL be ignored, with no m_ack_o asserted.

Reset
REQ-030 rst_i SHALL force state = ARB_IDLE, gnt_o = 0 and last_gnt = MASTER_NUM-1, so that master 0 has top priority after reset.
REQ-031 Reset asserted mid-tenure SHALL drop s_cyc_o, s_stb_o and every m_ack_o to 0 starting in the cycle after the reset edge.

Structure
REQ-032 Package wb_pkg SHALL hold the arb_state_t enum (ARB_IDLE, ARB_GRANTED).
REQ-033 A combinational sub-module wb_rr_picker SHALL take (req, last_gnt) and return the one-hot next grant; the top level SHALL hold state, gnt and last_gnt registers plus the muxes.

Verification
REQ-034 Single master: m_cyc_i=0001, write adr 0x0003 dat 0xDEADBEEF sel 1111 -> s_cyc_o at +1 clk, gnt_o=0001, and m_ack_o[0] mirrors s_ack_i.
REQ-035 All four masters request continuously after reset, each releasing after one ack -> grant order 0,1,2,3,0 with one idle cycle between tenures.
REQ-036 Master 2 holds cyc over an RMW of two strobes while master 1 requests -> no regrant until master 2 drops cyc; then master 3 is not requesting and master 1 is granted.
REQ-037 Master 1 drops cyc in the same cycle master 0 raises it (last_gnt=1) -> idle cycle, then gnt_o=0001.
REQ-038 rst_i pulsed during master 3's tenure -> s_cyc_o=0 and gnt_o=0 next cycle; with masters 0 and 3 requesting afterwards, master 0 is granted first.
REQ-039 s_ack_i forced to 1 in ARB_IDLE -> m_ack_o stays 0000.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone shared-bus arbiter.
// Holds the arbiter state encoding and the grant-index width helper.
package wb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_t;

    // Width of a binary master index; never narrower than one bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin picker: returns the one-hot grant for the first requester
// found searching upward from last_gnt+1 with wrap-around.
module wb_rr_picker
    import wb_pkg::*;
#(
    parameter  int MASTER_NUM = 4,
    localparam int IDX_W      = idx_width(MASTER_NUM)
) (
    input  logic [MASTER_NUM-1:0] req,
    input  logic [IDX_W-1:0]      last_gnt,
    output logic [MASTER_NUM-1:0] next_gnt
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // Rotating priority search; the previous owner is examined last.
    always_comb begin
        next_gnt = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 1; i <= MASTER_NUM; i++) begin
            idx = IDX_W'((int'(last_gnt) + i) % MASTER_NUM);
            if (!found && req[idx]) begin
                next_gnt[idx] = 1'b1;
                found         = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave among MASTER_NUM masters.
// A grant is held for the whole CYC tenure, so multi-phase cycles never split.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter  int ADDR_WIDTH = 16,
    parameter  int DATA_WIDTH = 32,
    parameter  int GRANULE    = 8,
    parameter  int MASTER_NUM = 4,
    localparam int SEL_WIDTH  = DATA_WIDTH / GRANULE,
    localparam int IDX_W      = idx_width(MASTER_NUM)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [MASTER_NUM-1:0]            m_cyc_i,
    input  logic [MASTER_NUM-1:0]            m_stb_i,
    input  logic [MASTER_NUM-1:0]            m_we_i,
    input  logic [MASTER_NUM*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [MASTER_NUM*DATA_WIDTH-1:0] m_dat_i,
    input  logic [MASTER_NUM*SEL_WIDTH-1:0]  m_sel_i,
    output logic [DATA_WIDTH-1:0]            m_dat_o,
    output logic [MASTER_NUM-1:0]            m_ack_o,
    output logic                             s_cyc_o,
    output logic                             s_stb_o,
    output logic                             s_we_o,
    output logic [ADDR_WIDTH-1:0]            s_adr_o,
    output logic [DATA_WIDTH-1:0]            s_dat_o,
    output logic [SEL_WIDTH-1:0]             s_sel_o,
    input  logic [DATA_WIDTH-1:0]            s_dat_i,
    input  logic                             s_ack_i,
    output logic [MASTER_NUM-1:0]            gnt_o
);

    arb_state_t            state;
    arb_state_t            next_state;
    logic [MASTER_NUM-1:0] gnt;
    logic [MASTER_NUM-1:0] next_gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic [IDX_W-1:0]      next_idx;
    logic [IDX_W-1:0]      last_gnt;
    logic [IDX_W-1:0]      next_last;
    logic [MASTER_NUM-1:0] pick;
    logic [IDX_W-1:0]      pick_idx;

    wb_rr_picker #(
        .MASTER_NUM (MASTER_NUM)
    ) u_picker (
        .req      (m_cyc_i),
        .last_gnt (last_gnt),
        .next_gnt (pick)
    );

    // Binary index of the picked master, kept alongside the one-hot grant.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end else begin
                pick_idx = pick_idx;
            end
        end
    end

    // Next-state logic: the owner keeps the bus until it drops its own CYC.
    always_comb begin
        next_state = state;
        next_gnt   = gnt;
        next_idx   = gnt_idx;
        next_last  = last_gnt;
        case (state)
            ARB_IDLE: begin
                if (|m_cyc_i) begin
                    next_state = ARB_GRANTED;
                    next_gnt   = pick;
                    next_idx   = pick_idx;
                end else begin
                    next_gnt   = '0;
                end
            end
            ARB_GRANTED: begin
                if (m_cyc_i[gnt_idx]) begin
                    next_state = ARB_GRANTED;
                end else begin
                    next_state = ARB_IDLE;
                    next_gnt   = '0;
                    next_last  = gnt_idx;
                end
            end
            default: begin
                next_state = ARB_IDLE;
                next_gnt   = '0;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ARB_IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            last_gnt <= IDX_W'(MASTER_NUM - 1);
        end else begin
            state    <= next_state;
            gnt      <= next_gnt;
            gnt_idx  <= next_idx;
            last_gnt <= next_last;
        end
    end

    assign gnt_o   = gnt;
    assign m_dat_o = s_dat_i;

    // Slave-side mux and ack routing; everything is quiet while idle,
    // so a stray slave ack never reaches a master.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        if (state == ARB_GRANTED) begin
            s_cyc_o = m_cyc_i[gnt_idx];
            s_stb_o = m_stb_i[gnt_idx] & m_cyc_i[gnt_idx];
            s_we_o  = m_we_i[gnt_idx];
            s_adr_o = m_adr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            s_dat_o = m_dat_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            s_sel_o = m_sel_i[gnt_idx*SEL_WIDTH +: SEL_WIDTH];
            m_ack_o = gnt & {MASTER_NUM{s_ack_i & m_cyc_i[gnt_idx]}};
        end else begin
            m_ack_o = '0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus queues expected grants and acks,
// a negedge monitor pops and compares them when the DUT presents them.
module tb_wb_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int N  = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [N*AW-1:0] m_adr_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N*SW-1:0] m_sel_i;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i;
    logic [N-1:0]    gnt_o;

    wb_arbiter #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .GRANULE (8), .MASTER_NUM (N)
    ) dut (
        .clk_i (clk_i), .rst_i (rst_i),
        .m_cyc_i (m_cyc_i), .m_stb_i (m_stb_i), .m_we_i (m_we_i),
        .m_adr_i (m_adr_i), .m_dat_i (m_dat_i), .m_sel_i (m_sel_i),
        .m_dat_o (m_dat_o), .m_ack_o (m_ack_o),
        .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o (s_we_o),
        .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o),
        .s_dat_i (s_dat_i), .s_ack_i (s_ack_i), .gnt_o (gnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [AW-1:0] adr;
        logic          we;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
    } exp_t;

    exp_t         exp_gnt_q[$];
    logic [N-1:0] exp_ack_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic         started  = 1'b0;
    logic [N-1:0] prev_gnt = '0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_master(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [SW-1:0] s, input logic w);
        m_adr_i[k*AW +: AW] = a;
        m_dat_i[k*DW +: DW] = d;
        m_sel_i[k*SW +: SW] = s;
        m_we_i[k]           = w;
    endtask

    task automatic push_gnt(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input logic w);
        exp_t e;
        e.gnt = N'(1) << k;
        e.adr = a;
        e.we  = w;
        e.dat = d;
        e.sel = s;
        exp_gnt_q.push_back(e);
    endtask

    task automatic wait_gnt(input string name);
        int cnt;
        cnt = 0;
        while (gnt_o == '0 && cnt < 20) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (gnt_o == '0) begin
            n_fail++;
            $display("FAIL %s: gnt_o stayed 0 for 20 cycles, expected a grant", name);
        end
    endtask

    // Monitor: bus invariants every cycle, scoreboard pops on grant start and slave ack.
    always @(negedge clk_i) begin
        if (started) begin
            exp_t e;
            exp_t a;
            logic bad;
            bad = (m_dat_o !== s_dat_i) || ((m_ack_o & ~gnt_o) != '0) || !$onehot0(gnt_o)
                  || (gnt_o == '0 && (s_cyc_o || s_stb_o || m_ack_o != '0 || s_adr_o != '0));
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL invariant: gnt=%b cyc=%b stb=%b ack=%b adr=%h dat_o=%h, required idle-quiet and m_dat_o=%h",
                         gnt_o, s_cyc_o, s_stb_o, m_ack_o, s_adr_o, m_dat_o, s_dat_i);
            end
            a.gnt = gnt_o; a.adr = s_adr_o; a.we = s_we_o; a.dat = s_dat_o; a.sel = s_sel_o;
            if (prev_gnt == '0 && gnt_o != '0) begin
                n_checks++;
                if (exp_gnt_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL grant: unexpected grant %b, required none", gnt_o);
                end else begin
                    e = exp_gnt_q.pop_front();
                    if (a !== e) begin
                        n_fail++;
                        $display("FAIL grant: got gnt=%b adr=%h we=%b dat=%h sel=%h required gnt=%b adr=%h we=%b dat=%h sel=%h",
                                 a.gnt, a.adr, a.we, a.dat, a.sel, e.gnt, e.adr, e.we, e.dat, e.sel);
                    end
                end
            end else if (prev_gnt != '0 && gnt_o != '0 && gnt_o != prev_gnt) begin
                n_checks++;
                n_fail++;
                $display("FAIL idle_gap: grant moved %b -> %b, required an idle cycle", prev_gnt, gnt_o);
            end
            if (s_ack_i) begin
                n_checks++;
                if (exp_ack_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ack: unexpected slave ack, m_ack_o=%b", m_ack_o);
                end else begin
                    logic [N-1:0] ea;
                    ea = exp_ack_q.pop_front();
                    if (m_ack_o !== ea) begin
                        n_fail++;
                        $display("FAIL ack: got m_ack_o=%b required %b", m_ack_o, ea);
                    end
                end
            end
            prev_gnt <= gnt_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        rst_i = 1'b1; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; s_dat_i = '0; s_ack_i = 1'b0;
        tick(); tick();
        started = 1'b1;
        check("rst_gnt", 64'(gnt_o), 64'h0);
        check("rst_cyc", 64'({s_cyc_o, s_stb_o}), 64'h0);
        check("rst_ack", 64'(m_ack_o), 64'h0);
        rst_i = 1'b0;

        // Stray ack while idle.
        s_dat_i = 32'h1234_5678;
        s_ack_i = 1'b1;
        exp_ack_q.push_back(4'b0000);
        tick();
        s_ack_i = 1'b0;
        check("stray_no_gnt", 64'(gnt_o), 64'h0);

        // Single master write, one-clock grant latency.
        set_master(0, 16'h0003, 32'hDEAD_BEEF, 4'hF, 1'b1);
        push_gnt(0, 16'h0003, 32'hDEAD_BEEF, 4'hF, 1'b1);
        m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
        check("lat_before", 64'(s_cyc_o), 64'h0);
        tick();
        check("lat_gnt", 64'(gnt_o), 64'h1);
        check("lat_cyc_stb", 64'({s_cyc_o, s_stb_o}), 64'h3);
        s_ack_i = 1'b1;
        exp_ack_q.push_back(4'b0001);
        tick();
        s_ack_i = 1'b0;
        m_cyc_i = '0; m_stb_i = '0;
        tick();
        check("single_release", 64'(gnt_o), 64'h0);

        // All four requesting continuously after reset: 0,1,2,3,0.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            set_master(k, 16'h0100 + 16'(k), 32'hC0DE_0000 + 32'(k), 4'(k + 1), k[0]);
        end
        for (int i = 0; i < 5; i++) begin
            push_gnt(order[i], 16'h0100 + 16'(order[i]), 32'hC0DE_0000 + 32'(order[i]),
                     4'(order[i] + 1), order[i][0]);
        end
        m_cyc_i = 4'hF; m_stb_i = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_gnt("rr_wait");
            s_ack_i = 1'b1;
            exp_ack_q.push_back(4'(1) << order[i]);
            tick();
            s_ack_i = 1'b0;
            m_cyc_i[order[i]] = 1'b0; m_stb_i[order[i]] = 1'b0;
            tick();
            check("rr_idle_gap", 64'(gnt_o), 64'h0);
            if (i < 4) begin
                m_cyc_i[order[i]] = 1'b1; m_stb_i[order[i]] = 1'b1;
            end else begin
                m_cyc_i = '0; m_stb_i = '0;
            end
        end

        // Master 2 read-modify-write while master 1 waits.
        set_master(2, 16'h0200, 32'h2222_0000, 4'h3, 1'b0);
        set_master(1, 16'h0110, 32'h1111_0000, 4'hC, 1'b1);
        push_gnt(2, 16'h0200, 32'h2222_0000, 4'h3, 1'b0);
        m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
        tick();
        check("rmw_gnt", 64'(gnt_o), 64'h4);
        push_gnt(1, 16'h0110, 32'h1111_0000, 4'hC, 1'b1);
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
        s_ack_i = 1'b1;
        exp_ack_q.push_back(4'b0100);
        tick();
        s_ack_i = 1'b0;
        m_stb_i[2] = 1'b0;
        check("rmw_hold1", 64'(gnt_o), 64'h4);
        tick();
        set_master(2, 16'h0200, 32'h2222_00FF, 4'h3, 1'b1);
        m_stb_i[2] = 1'b1;
        s_ack_i = 1'b1;
        exp_ack_q.push_back(4'b0100);
        check("rmw_hold2", 64'(gnt_o), 64'h4);
        tick();
        s_ack_i = 1'b0;
        m_cyc_i[2] = 1'b0; m_stb_i[2] = 1'b0;
        check("rmw_hold3", 64'(gnt_o), 64'h4);
        tick();
        check("rmw_idle", 64'(gnt_o), 64'h0);
        tick();
        check("rmw_next", 64'(gnt_o), 64'h2);

        // Master 1 releases as master 0 raises CYC.
        s_ack_i = 1'b1;
        exp_ack_q.push_back(4'b0010);
        tick();
        s_ack_i = 1'b0;
        set_master(0, 16'h0007, 32'h0000_0077, 4'h1, 1'b0);
        push_gnt(0, 16'h0007, 32'h0000_0077, 4'h1, 1'b0);
        m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
        tick();
        check("swap_idle", 64'(gnt_o), 64'h0);
        tick();
        check("swap_gnt", 64'(gnt_o), 64'h1);
        m_cyc_i = '0; m_stb_i = '0;
        tick(); tick();

        // Reset during master 3's tenure; master 0 wins afterwards.
        set_master(3, 16'h0300, 32'h3333_3333, 4'hF, 1'b1);
        push_gnt(3, 16'h0300, 32'h3333_3333, 4'hF, 1'b1);
        m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
        tick();
        check("pre_rst_gnt", 64'(gnt_o), 64'h8);
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_gnt", 64'(gnt_o), 64'h0);
        check("mid_rst_cyc", 64'({s_cyc_o, s_stb_o}), 64'h0);
        push_gnt(0, 16'h0007, 32'h0000_0077, 4'h1, 1'b0);
        s_ack_i = 1'b1;
        exp_ack_q.push_back(4'b0000);
        tick();
        s_ack_i = 1'b0;
        check("post_rst_gnt", 64'(gnt_o), 64'h1);
        m_cyc_i = '0; m_stb_i = '0;
        tick(); tick();

        check("gnt_queue_empty", 64'(exp_gnt_q.size()), 64'h0);
        check("ack_queue_empty", 64'(exp_ack_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
